alu_result_collector: RTL and testbench

- Downstream stage of the ALU functional units (adder, comparator, logic unit, shifter); all units register their outputs one cycle after dat_ready.
- Tracks each issued op for one cycle and selects the result of the unit that owns the op code.
- Buffers results in a small FIFO and presents them to writeback over a valid/ready handshake.
- Drives alu_ready back to the dispatcher as credit-based backpressure.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_collect_fifo.sv | 50 +++++
 rtl/alu_result_collector.sv | 97 +++++++++
 tb/tb_alu_result_collector.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, functional-unit ids and the op-to-unit mapping.
// Used by the dispatcher, the ALU units and the result collector.
package alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned ENTRY_W = XLEN + RD_W + 1;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_SLT  = 5'd2,
        OP_SLTU = 5'd3,
        OP_XOR  = 5'd4,
        OP_OR   = 5'd5,
        OP_AND  = 5'd6,
        OP_SLL  = 5'd8,
        OP_SRL  = 5'd12,
        OP_SRA  = 5'd13
    } alu_op_e;

    typedef enum logic [2:0] {
        ADDER,
        COMPARE,
        LOGIC,
        SHIFT,
        NONE
    } alu_unit_e;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RD_W-1:0] rd;
        logic            illegal;
    } alu_result_t;

    // Takes a raw code so undefined encodings map cleanly to NONE.
    function automatic alu_unit_e op_to_unit(input logic [OP_W-1:0] op);
        alu_unit_e unit;
        unit = NONE;
        case (op)
            OP_ADD, OP_SUB:         unit = ADDER;
            OP_SLT, OP_SLTU:        unit = COMPARE;
            OP_XOR, OP_OR, OP_AND:  unit = LOGIC;
            OP_SLL, OP_SRL, OP_SRA: unit = SHIFT;
            default:                unit = NONE;
        endcase
        return unit;
    endfunction

endpackage

// File: rtl/alu_collect_fifo.sv
// Synchronous result FIFO with push, pop, flush and occupancy count.
// Head is read straight from registered storage; it reads as zero when empty.
module alu_collect_fifo #(
    parameter int unsigned WIDTH = 38,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     soc_clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge soc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !do_pop)      count <= count + CW'(1);
            else if (!push && do_pop) count <= count - CW'(1);
        end
    end

    // When full, push and pop share a slot: the old head is read this cycle, overwritten at the edge.
    always_ff @(posedge soc_clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU unit results one cycle after issue, buffers them and hands them to writeback.
// Optional macro ALU_COLLECT_X0_FILTER_EN: results targeting rd==0 are not buffered.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   soc_clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   dat_ready,
    input  logic [4:0]             Instruction_to_ALU,
    input  logic [4:0]             rd_addr,
    input  logic [XLEN-1:0]        Adder_out,
    input  logic [XLEN-1:0]        Compare_out,
    input  logic [XLEN-1:0]        Logic_out,
    input  logic [XLEN-1:0]        Shifter_out,
    output logic                   alu_ready,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [XLEN-1:0]        wb_data,
    output logic [4:0]             wb_rd,
    output logic                   wb_illegal,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            issue;
    logic            s1_valid;
    logic [OP_W-1:0] s1_op;
    logic [RD_W-1:0] s1_rd;
    alu_result_t     collected;
    alu_result_t     head;
    logic            push;
    logic [CW:0]     credit_used;

    assign issue = dat_ready && alu_ready;

    always_ff @(posedge soc_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_rd    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_op <= Instruction_to_ALU;
                s1_rd <= rd_addr;
            end
        end
    end

    always_comb begin
        collected    = '0;
        collected.rd = s1_rd;
        case (op_to_unit(s1_op))
            ADDER:   collected.data = Adder_out;
            COMPARE: collected.data = Compare_out;
            LOGIC:   collected.data = Logic_out;
            SHIFT:   collected.data = Shifter_out;
            default: collected.illegal = 1'b1;
        endcase
    end

`ifdef ALU_COLLECT_X0_FILTER_EN
    assign push = s1_valid && (s1_rd != '0);
`else
    assign push = s1_valid;
`endif

    // Credit counts the op still in stage 1, so the FIFO can never overflow.
    assign credit_used = {1'b0, fifo_count} + (CW+1)'(s1_valid);
    assign alu_ready   = credit_used < (CW+1)'(DEPTH);

    alu_collect_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .soc_clk   (soc_clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push),
        .push_data (collected),
        .pop       (wb_valid && wb_ready),
        .head_data (head),
        .count     (fifo_count)
    );

    assign wb_valid   = fifo_count != '0;
    assign wb_data    = head.data;
    assign wb_rd      = head.rd;
    assign wb_illegal = head.illegal;

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed scenarios plus a randomized run against a queue model.
module tb_alu_result_collector;
    import alu_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        soc_clk;
    logic        reset_n;
    logic        flush;
    logic        dat_ready;
    logic [4:0]  Instruction_to_ALU;
    logic [4:0]  rd_addr;
    logic [31:0] Adder_out;
    logic [31:0] Compare_out;
    logic [31:0] Logic_out;
    logic [31:0] Shifter_out;
    logic        alu_ready;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_illegal;
    logic [2:0]  fifo_count;

    alu_result_collector #(.DEPTH(DEPTH)) dut (
        .soc_clk            (soc_clk),
        .reset_n            (reset_n),
        .flush              (flush),
        .dat_ready          (dat_ready),
        .Instruction_to_ALU (Instruction_to_ALU),
        .rd_addr            (rd_addr),
        .Adder_out          (Adder_out),
        .Compare_out        (Compare_out),
        .Logic_out          (Logic_out),
        .Shifter_out        (Shifter_out),
        .alu_ready          (alu_ready),
        .wb_valid           (wb_valid),
        .wb_ready           (wb_ready),
        .wb_data            (wb_data),
        .wb_rd              (wb_rd),
        .wb_illegal         (wb_illegal),
        .fifo_count         (fifo_count)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        ill;
    } res_t;

    res_t       exp_q[$];
    bit         m_s1v;
    logic [4:0] m_op;
    logic [4:0] m_rd;
    bit         hold_units;
    int         checks;
    int         errors;
    logic [4:0] legal_ops [10];

    function automatic bit model_ready();
        return (exp_q.size() + int'(m_s1v)) < int'(DEPTH);
    endfunction

    function automatic res_t model_result(input logic [4:0] op, input logic [4:0] rd);
        res_t r;
        r.rd = rd; r.ill = 1'b0; r.data = '0;
        if (op inside {5'd0, 5'd1})               r.data = Adder_out;
        else if (op inside {5'd2, 5'd3})          r.data = Compare_out;
        else if (op inside {5'd4, 5'd5, 5'd6})    r.data = Logic_out;
        else if (op inside {5'd8, 5'd12, 5'd13})  r.data = Shifter_out;
        else                                      r.ill  = 1'b1;
        return r;
    endfunction

    function automatic bit model_keeps(input res_t r);
`ifdef ALU_COLLECT_X0_FILTER_EN
        return r.rd != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        m_s1v = 1'b0;
    endfunction

    // Called at a falling edge: drives one cycle of inputs, advances the model, returns at the next falling edge.
    task automatic step(input bit dr, input logic [4:0] op, input logic [4:0] rd, input bit wr, input bit fl);
        bit   iss;
        bit   pop_ok;
        res_t r;
        if (!hold_units) begin
            Adder_out   = $urandom;
            Compare_out = $urandom;
            Logic_out   = $urandom;
            Shifter_out = $urandom;
        end
        dat_ready = dr; Instruction_to_ALU = op; rd_addr = rd; wb_ready = wr; flush = fl;
        iss    = dr && model_ready();
        pop_ok = (exp_q.size() != 0) && wr;
        if (fl) begin
            model_clear();
        end else begin
            r = model_result(m_op, m_rd);
            if (pop_ok) void'(exp_q.pop_front());
            if (m_s1v && model_keeps(r)) exp_q.push_back(r);
            m_s1v = iss;
            if (iss) begin m_op = op; m_rd = rd; end
        end
        @(posedge soc_clk);
        @(negedge soc_clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 0; dat_ready = 0; wb_ready = 0;
        Instruction_to_ALU = '0; rd_addr = '0;
        Adder_out = '0; Compare_out = '0; Logic_out = '0; Shifter_out = '0;
        model_clear();
        repeat (2) @(negedge soc_clk);
        checks++;
        if (wb_valid !== 1'b0 || fifo_count !== 3'd0 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b count=%0d ready=%b, required valid=0 count=0 ready=1", wb_valid, fifo_count, alu_ready);
        end
        checks++;
        if (wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: data=%h rd=%0d ill=%b, required 0/0/0", wb_data, wb_rd, wb_illegal);
        end
        reset_n = 1'b1;
        @(negedge soc_clk);
    endtask

    task automatic test_single_op();
        step(0, 5'd0, 5'd0, 1, 1);
        step(1, 5'd8, 5'd5, 0, 0);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: wb_valid=%b at N+1, required 0", wb_valid);
        end
        hold_units = 1'b1;
        Adder_out = $urandom; Compare_out = $urandom; Logic_out = $urandom; Shifter_out = 32'h0000_0010;
        step(0, 5'd0, 5'd0, 0, 0);
        hold_units = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h10 || wb_rd !== 5'd5 || wb_illegal !== 1'b0) begin
            errors++;
            $display("FAIL single_op: valid=%b data=%h rd=%0d ill=%b, required 1/00000010/5/0", wb_valid, wb_data, wb_rd, wb_illegal);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [4];
        ops[0] = 5'd0; ops[1] = 5'd13; ops[2] = 5'd6; ops[3] = 5'd3;
        step(0, 5'd0, 5'd0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (alu_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: cycle %0d alu_ready=%b, required 1", i, alu_ready);
            end
            step(i < 4, (i < 4) ? ops[i] : 5'd0, 5'(i + 1), 1, 0);
            if (i >= 1 && i <= 4) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_rd !== 5'(i) || exp_q.size() == 0 || wb_data !== exp_q[0].data) begin
                    errors++;
                    $display("FAIL b2b_order: slot %0d valid=%b rd=%0d data=%h, required valid=1 rd=%0d data=%h",
                             i, wb_valid, wb_rd, wb_data, i, (exp_q.size() != 0) ? exp_q[0].data : 32'hx);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          accepted;
        logic [31:0] held_data;
        accepted = 0;
        step(0, 5'd0, 5'd0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (alu_ready !== model_ready()) begin
                errors++;
                $display("FAIL bp_ready: cycle %0d alu_ready=%b, required %b", i, alu_ready, model_ready());
            end
            if (alu_ready === 1'b1) accepted++;
            step(1, legal_ops[$urandom_range(0, 9)], 5'(i + 1), 0, 0);
            if (i == 2) held_data = wb_data;
        end
        checks++;
        if (accepted !== 4 || fifo_count !== 3'd4 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill: accepted=%0d count=%0d ready=%b, required 4/4/0", accepted, fifo_count, alu_ready);
        end
        checks++;
        if (wb_rd !== 5'd1 || wb_data !== held_data) begin
            errors++;
            $display("FAIL bp_hold: rd=%0d data=%h, required rd=1 data=%h", wb_rd, wb_data, held_data);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 5'd0, 5'd0, 1, 0);
            checks++;
            if (int'(fifo_count) !== 3 - i || alu_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_drain: pop %0d count=%0d ready=%b, required count=%0d ready=1", i, fifo_count, alu_ready, 3 - i);
            end
            if (i < 3) begin
                checks++;
                if (wb_rd !== 5'(i + 2) || wb_data !== exp_q[0].data) begin
                    errors++;
                    $display("FAIL bp_drain_head: pop %0d rd=%0d data=%h, required rd=%0d data=%h", i, wb_rd, wb_data, i + 2, exp_q[0].data);
                end
            end
        end
    endtask

    task automatic test_illegal();
        step(0, 5'd0, 5'd0, 1, 1);
        step(1, 5'd7, 5'd9, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0);
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0 || wb_illegal !== 1'b1 || wb_rd !== 5'd9) begin
            errors++;
            $display("FAIL illegal: valid=%b data=%h ill=%b rd=%0d, required 1/0/1/9", wb_valid, wb_data, wb_illegal, wb_rd);
        end
    endtask

    task automatic fill_three_plus_one();
        step(0, 5'd0, 5'd0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, legal_ops[$urandom_range(0, 9)], 5'(i + 1), 0, 0);
        checks++;
        if (fifo_count !== 3'd3 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL prefill: count=%0d ready=%b, required 3/0", fifo_count, alu_ready);
        end
    endtask

    task automatic test_flush();
        fill_three_plus_one();
        step(1, 5'd0, 5'd6, 0, 1);
        checks++;
        if (fifo_count !== 3'd0 || wb_valid !== 1'b0 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: count=%0d valid=%b ready=%b, required 0/0/1", fifo_count, wb_valid, alu_ready);
        end
        step(0, 5'd0, 5'd0, 0, 0);
        checks++;
        if (fifo_count !== 3'd0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: count=%0d valid=%b, required 0/0", fifo_count, wb_valid);
        end
    endtask

    task automatic test_reset_mid();
        fill_three_plus_one();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (fifo_count !== 3'd0 || wb_valid !== 1'b0 || alu_ready !== 1'b1 ||
            wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: count=%0d valid=%b ready=%b data=%h rd=%0d ill=%b, required 0/0/1/0/0/0",
                     fifo_count, wb_valid, alu_ready, wb_data, wb_rd, wb_illegal);
        end
        model_clear();
        dat_ready = 1'b0;
        @(negedge soc_clk);
        reset_n = 1'b1;
        step(0, 5'd0, 5'd0, 0, 0);
        checks++;
        if (fifo_count !== 3'd0 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: count=%0d ready=%b, required 0/1", fifo_count, alu_ready);
        end
    endtask

    task automatic test_x0_filter();
        int         exp_cnt;
        logic [4:0] exp_rd;
`ifdef ALU_COLLECT_X0_FILTER_EN
        exp_cnt = 1; exp_rd = 5'd3;
`else
        exp_cnt = 2; exp_rd = 5'd0;
`endif
        step(0, 5'd0, 5'd0, 1, 1);
        step(1, 5'd5, 5'd0, 0, 0);
        step(1, 5'd4, 5'd3, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0);
        checks++;
        if (int'(fifo_count) !== exp_cnt || wb_rd !== exp_rd || wb_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL x0_filter: count=%0d rd=%0d data=%h, required count=%0d rd=%0d data=%h",
                     fifo_count, wb_rd, wb_data, exp_cnt, exp_rd, exp_q[0].data);
        end
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (alu_ready !== model_ready() || int'(fifo_count) !== exp_q.size() || wb_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_ctrl: cycle %0d ready=%b count=%0d valid=%b, required ready=%b count=%0d valid=%b",
                         c, alu_ready, fifo_count, wb_valid, model_ready(), exp_q.size(), exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (wb_data !== exp_q[0].data || wb_rd !== exp_q[0].rd || wb_illegal !== exp_q[0].ill) begin
                    errors++;
                    $display("FAIL rand_head: cycle %0d data=%h rd=%0d ill=%b, required data=%h rd=%0d ill=%b",
                             c, wb_data, wb_rd, wb_illegal, exp_q[0].data, exp_q[0].rd, exp_q[0].ill);
                end
            end
            op = ($urandom_range(0, 99) < 85) ? legal_ops[$urandom_range(0, 9)] : 5'($urandom_range(0, 31));
            step($urandom_range(0, 99) < 75, op,
                 ($urandom_range(0, 99) < 15) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
        end
    endtask

    initial begin
        checks = 0; errors = 0; hold_units = 1'b0;
        m_op = '0; m_rd = '0;
        legal_ops[0] = 5'd0;  legal_ops[1] = 5'd1;  legal_ops[2] = 5'd2;  legal_ops[3] = 5'd3;
        legal_ops[4] = 5'd4;  legal_ops[5] = 5'd5;  legal_ops[6] = 5'd6;  legal_ops[7] = 5'd8;
        legal_ops[8] = 5'd12; legal_ops[9] = 5'd13;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_x0_filter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
